// File: rtl/player_key_decoder.sv
// player_key_decoder
//   Decodes PS/2 set-2 scan-code bytes into per-frame key levels for the player.
//   Make/break sequences are decoded, including the E0 extended prefix. A held-key
//   register tracks which keys are currently down. A tap-seen register records any
//   make since the last frame, so that a tap shorter than one frame is still reported
//   for a full frame. The outputs are latched once per frame, on startOfFrame.
//
//   state   | meaning
//   --------+------------------------------------------
//   IDLE    | no prefix pending
//   EXT     | E0 seen, next code is an extended make
//   BRK     | F0 seen, next code is a break
//   EXT_BRK | E0 and F0 seen, next code is an extended break
//
// Ports
//   clk, resetN      clock and asynchronous active-low reset
//   startOfFrame     one-clk pulse per frame
//   code_valid       one-clk strobe; code_byte is valid on that clk
//   code_byte        received scan-code byte
//   move_left/right/up/down, fire   key levels, constant for the whole frame
//   fire_pulse       one-clk pulse when fire rises from 0 to 1
module player_key_decoder #(
  parameter logic [7:0]  KEY_LEFT       = 8'h6B,
  parameter logic [7:0]  KEY_RIGHT      = 8'h74,
  parameter logic [7:0]  KEY_UP         = 8'h75,
  parameter logic [7:0]  KEY_DOWN       = 8'h72,
  parameter logic [7:0]  KEY_FIRE       = 8'h29,
  parameter bit          ACCEPT_NUMPAD  = 1'b1,
  parameter int unsigned PREFIX_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       code_valid,
  input  logic [7:0] code_byte,
  output logic       move_left,
  output logic       move_right,
  output logic       move_up,
  output logic       move_down,
  output logic       fire,
  output logic       fire_pulse
);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam int CNT_W = $clog2(PREFIX_TIMEOUT + 1);
  // The prefix is dropped on the idle clk that would bring the count to PREFIX_TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

  // Key bit order: 0 left, 1 right, 2 up, 3 down, 4 fire.
  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       key_held_q, key_held_d;
  logic [4:0]       tap_seen_q, tap_seen_d;
  logic [4:0]       keys_q, keys_d;
  logic             fire_pulse_q, fire_pulse_d;

  logic       make_v, brk_v, ext_v, dir_ok;
  logic [4:0] hit;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      key_held_q   <= '0;
      tap_seen_q   <= '0;
      keys_q       <= '0;
      fire_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      key_held_q   <= key_held_d;
      tap_seen_q   <= tap_seen_d;
      keys_q       <= keys_d;
      fire_pulse_q <= fire_pulse_d;
    end
  end

  // Sequence FSM and prefix timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    make_v  = 1'b0;
    brk_v   = 1'b0;
    ext_v   = 1'b0;
    if (code_valid) begin
      cnt_d = '0;
      case (state_q)
        S_IDLE: begin
          if (code_byte == CODE_EXT)      state_d = S_EXT;
          else if (code_byte == CODE_BRK) state_d = S_BRK;
          else                            make_v  = 1'b1;
        end
        S_EXT: begin
          if (code_byte == CODE_BRK) state_d = S_EXT_BRK;
          else if (code_byte != CODE_EXT) begin
            make_v  = 1'b1;
            ext_v   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BRK: begin
          if (code_byte == CODE_EXT) state_d = S_EXT_BRK;
          else if (code_byte != CODE_BRK) begin
            brk_v   = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: begin
          if (code_byte != CODE_EXT && code_byte != CODE_BRK) begin
            brk_v   = 1'b1;
            ext_v   = 1'b1;
            state_d = S_IDLE;
          end
        end
      endcase
    end else if (state_q != S_IDLE) begin
      if (cnt_q == CNT_LAST) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Key match, held/tap tracking and per-frame latch
  always_comb begin
    dir_ok = ext_v | ACCEPT_NUMPAD;
    hit    = '0;
    hit[0] = dir_ok && (code_byte == KEY_LEFT);
    hit[1] = dir_ok && (code_byte == KEY_RIGHT);
    hit[2] = dir_ok && (code_byte == KEY_UP);
    hit[3] = dir_ok && (code_byte == KEY_DOWN);
    hit[4] = !ext_v && (code_byte == KEY_FIRE);

    key_held_d = key_held_q;
    if (make_v) key_held_d = key_held_q | hit;
    if (brk_v)  key_held_d = key_held_q & ~hit;

    // A make on the frame clk survives the clear and is reported next frame.
    tap_seen_d = startOfFrame ? '0 : tap_seen_q;
    if (make_v) tap_seen_d = tap_seen_d | hit;

    keys_d       = keys_q;
    fire_pulse_d = 1'b0;
    if (startOfFrame) begin
      keys_d       = key_held_q | tap_seen_q;
      fire_pulse_d = keys_d[4] & ~keys_q[4];
    end
  end

  assign move_left  = keys_q[0];
  assign move_right = keys_q[1];
  assign move_up    = keys_q[2];
  assign move_down  = keys_q[3];
  assign fire       = keys_q[4];
  assign fire_pulse = fire_pulse_q;

endmodule
